dtl_rect_fill: RTL and testbench

- DTL master that fills axis-aligned rectangles of the 320x240x8 VGA framebuffer with a constant colour.
- Sits directly upstream of the DTL VGA slave and writes its framebuffer over the DTL write path.
- Control side is a single-command valid/accept port driven by the processor-side register block.
- Turns each command into row-by-row DTL write bursts of at most MAX_BURST words.

---
 rtl/dtl_rect_fill.sv | 248 ++++++++++++++++++++++++
 tb/tb_dtl_rect_fill.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtl_rect_fill.sv
// dtl_rect_fill: DTL write master that fills an axis-aligned rectangle of the
// 320x240x8 framebuffer with a constant colour, one pixel per DTL word.
// Each row is split into write bursts of at most MAX_BURST words.
// Optional clipping to the visible framebuffer: define DTL_RECT_FILL_CLIP_EN.
//
// Handshake rules: a transfer happens on a rising edge where valid and its
// accept are both high; a valid, once raised, holds itself and all qualifying
// fields stable until that edge. oFill_Accept is a ready that is only raised
// in IDLE; a fill command is taken on an edge with iFill_Valid && oFill_Accept.
// Command and data phases never overlap.
module dtl_rect_fill #(
    parameter int INTERFACE_WIDTH       = 32,
    parameter int INTERFACE_ADDR_WIDTH  = 32,
    parameter int INTERFACE_BLOCK_WIDTH = 5,
    parameter int DISPLAY_RES_X         = 320,
    parameter int DISPLAY_RES_Y         = 240,
    parameter logic [INTERFACE_ADDR_WIDTH-1:0] BASE_ADDRESS = '0,
    // Must be in 1..2**INTERFACE_BLOCK_WIDTH.
    parameter int MAX_BURST             = 16
) (
    input  logic                               iClk,
    input  logic                               iReset,
    input  logic                               iFill_Valid,
    output logic                               oFill_Accept,
    input  logic [8:0]                         iFill_X,
    input  logic [7:0]                         iFill_Y,
    input  logic [9:0]                         iFill_W,
    input  logic [8:0]                         iFill_H,
    input  logic [7:0]                         iFill_Colour,
    output logic                               oBusy,
    output logic                               oDone,
    output logic                               oDTL_CommandValid,
    input  logic                               iDTL_CommandAccept,
    output logic [INTERFACE_ADDR_WIDTH-1:0]    oDTL_Address,
    output logic                               oDTL_CommandReadWrite,
    output logic [INTERFACE_BLOCK_WIDTH-1:0]   oDTL_BlockSize,
    output logic                               oDTL_WriteValid,
    output logic                               oDTL_WriteLast,
    input  logic                               iDTL_WriteAccept,
    output logic [INTERFACE_WIDTH/8-1:0]       oDTL_WriteEnable,
    output logic [INTERFACE_WIDTH-1:0]         oDTL_WriteData,
    output logic [2:0]                         oDebug_State
);

    localparam int AW    = INTERFACE_ADDR_WIDTH;
    localparam int BW    = INTERFACE_BLOCK_WIDTH;
    localparam int BYTES = INTERFACE_WIDTH / 8;
    localparam int LW    = $clog2(MAX_BURST + 1);

    localparam logic [9:0] MAX_BURST_10 = 10'(MAX_BURST);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_DATA = 3'd2,
        S_NEXT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state;

    // Working registers. Row/column are wide enough for unclipped
    // rectangles that run past the framebuffer edge.
    logic [8:0]  x_start;
    logic [9:0]  width;
    logic [9:0]  row;
    logic [10:0] col;
    logic [9:0]  remaining;
    logic [8:0]  rows_left;
    logic [LW-1:0] len;
    logic [LW-1:0] beat;

    // Effective rectangle seen in IDLE (after optional clipping).
    logic [9:0]  eff_w;
    logic [8:0]  eff_h;
    logic        empty;

    // Values for the burst that follows the one just finished.
    logic [9:0]  nxt_rem;
    logic [10:0] nxt_col;
    logic [9:0]  nxt_row;

    assign oDTL_CommandReadWrite = 1'b1;
    assign oDebug_State          = state;

    // Burst length for a given number of pixels still to write in the row.
    function automatic logic [LW-1:0] burst_len(input logic [9:0] rem);
        if (rem > MAX_BURST_10)
            return LW'(MAX_BURST);
        else
            return LW'(rem);
    endfunction

    // Byte address of pixel (r, c), wrapping at the address width.
    function automatic logic [AW-1:0] pixel_addr(input logic [9:0] r,
                                                 input logic [10:0] c);
        return BASE_ADDRESS
             + (AW'(r) * AW'(DISPLAY_RES_X) + AW'(c)) * AW'(BYTES);
    endfunction

`ifdef DTL_RECT_FILL_CLIP_EN
    localparam logic [9:0] RES_X_10 = 10'(DISPLAY_RES_X);
    localparam logic [8:0] RES_Y_9  = 9'(DISPLAY_RES_Y);

    logic [9:0] x_room;
    logic [8:0] y_room;

    // Clip the incoming rectangle to the visible framebuffer.
    always_comb begin
        x_room = RES_X_10 - {1'b0, iFill_X};
        y_room = RES_Y_9 - {1'b0, iFill_Y};
        eff_w  = (iFill_W > x_room) ? x_room : iFill_W;
        eff_h  = (iFill_H > y_room) ? y_room : iFill_H;
        empty  = ({1'b0, iFill_X} >= RES_X_10) || ({1'b0, iFill_Y} >= RES_Y_9)
              || (eff_w == '0) || (eff_h == '0);
    end
`else
    // No clipping: the caller keeps the rectangle inside the framebuffer.
    always_comb begin
        eff_w = iFill_W;
        eff_h = iFill_H;
        empty = (iFill_W == '0) || (iFill_H == '0);
    end
`endif

    // Position and length bookkeeping for the burst after the current one.
    always_comb begin
        nxt_rem = remaining - 10'(len);
        nxt_col = col + 11'(len);
        nxt_row = row + 10'd1;
    end

    // Control FSM; every output is registered alongside the state.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state             <= S_IDLE;
            oFill_Accept      <= 1'b0;
            oBusy             <= 1'b0;
            oDone             <= 1'b0;
            oDTL_CommandValid <= 1'b0;
            oDTL_Address      <= '0;
            oDTL_BlockSize    <= '0;
            oDTL_WriteValid   <= 1'b0;
            oDTL_WriteLast    <= 1'b0;
            oDTL_WriteEnable  <= '0;
            oDTL_WriteData    <= '0;
            x_start           <= '0;
            width             <= '0;
            row               <= '0;
            col               <= '0;
            remaining         <= '0;
            rows_left         <= '0;
            len               <= '0;
            beat              <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    oFill_Accept <= 1'b1;
                    if (iFill_Valid && oFill_Accept) begin
                        oFill_Accept   <= 1'b0;
                        oBusy          <= 1'b1;
                        oDTL_WriteData <= {{(INTERFACE_WIDTH-8){1'b0}}, iFill_Colour};
                        x_start        <= iFill_X;
                        width          <= eff_w;
                        row            <= {2'b00, iFill_Y};
                        col            <= {2'b00, iFill_X};
                        remaining      <= eff_w;
                        rows_left      <= eff_h;
                        if (empty) begin
                            state <= S_DONE;
                            oDone <= 1'b1;
                        end else begin
                            state             <= S_CMD;
                            oDTL_CommandValid <= 1'b1;
                            oDTL_Address      <= pixel_addr({2'b00, iFill_Y}, {2'b00, iFill_X});
                            len               <= burst_len(eff_w);
                            oDTL_BlockSize    <= BW'(burst_len(eff_w) - LW'(1));
                        end
                    end
                end

                S_CMD: begin
                    if (iDTL_CommandAccept) begin
                        state             <= S_DATA;
                        oDTL_CommandValid <= 1'b0;
                        oDTL_WriteValid   <= 1'b1;
                        oDTL_WriteEnable  <= '1;
                        oDTL_WriteLast    <= (len == LW'(1));
                        beat              <= '0;
                    end
                end

                S_DATA: begin
                    if (iDTL_WriteAccept) begin
                        if (beat == len - LW'(1)) begin
                            state            <= S_NEXT;
                            oDTL_WriteValid  <= 1'b0;
                            oDTL_WriteLast   <= 1'b0;
                            oDTL_WriteEnable <= '0;
                        end else begin
                            beat           <= beat + LW'(1);
                            oDTL_WriteLast <= ((beat + LW'(1)) == (len - LW'(1)));
                        end
                    end
                end

                S_NEXT: begin
                    if (nxt_rem != '0) begin
                        // More of the current row to write.
                        state             <= S_CMD;
                        remaining         <= nxt_rem;
                        col               <= nxt_col;
                        oDTL_CommandValid <= 1'b1;
                        oDTL_Address      <= pixel_addr(row, nxt_col);
                        len               <= burst_len(nxt_rem);
                        oDTL_BlockSize    <= BW'(burst_len(nxt_rem) - LW'(1));
                    end else if (rows_left == 9'd1) begin
                        state <= S_DONE;
                        oDone <= 1'b1;
                    end else begin
                        // Start the next row from the left edge.
                        state             <= S_CMD;
                        rows_left         <= rows_left - 9'd1;
                        row               <= nxt_row;
                        col               <= {2'b00, x_start};
                        remaining         <= width;
                        oDTL_CommandValid <= 1'b1;
                        oDTL_Address      <= pixel_addr(nxt_row, {2'b00, x_start});
                        len               <= burst_len(width);
                        oDTL_BlockSize    <= BW'(burst_len(width) - LW'(1));
                    end
                end

                S_DONE: begin
                    state        <= S_IDLE;
                    oDone        <= 1'b0;
                    oBusy        <= 1'b0;
                    oFill_Accept <= 1'b1;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dtl_rect_fill.sv
// tb_dtl_rect_fill: directed bench for dtl_rect_fill. Inputs are driven and
// outputs sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_dtl_rect_fill;

  logic        iClk;
  logic        iReset;
  logic        iFill_Valid;
  logic        oFill_Accept;
  logic [8:0]  iFill_X;
  logic [7:0]  iFill_Y;
  logic [9:0]  iFill_W;
  logic [8:0]  iFill_H;
  logic [7:0]  iFill_Colour;
  logic        oBusy;
  logic        oDone;
  logic        oDTL_CommandValid;
  logic        iDTL_CommandAccept;
  logic [31:0] oDTL_Address;
  logic        oDTL_CommandReadWrite;
  logic [4:0]  oDTL_BlockSize;
  logic        oDTL_WriteValid;
  logic        oDTL_WriteLast;
  logic        iDTL_WriteAccept;
  logic [3:0]  oDTL_WriteEnable;
  logic [31:0] oDTL_WriteData;
  logic [2:0]  oDebug_State;

  int vectors     = 0;
  int miscompares = 0;
  int total_beats = 0;
  int done_cnt    = 0;

  dtl_rect_fill dut (
    .iClk                 (iClk),
    .iReset               (iReset),
    .iFill_Valid          (iFill_Valid),
    .oFill_Accept         (oFill_Accept),
    .iFill_X              (iFill_X),
    .iFill_Y              (iFill_Y),
    .iFill_W              (iFill_W),
    .iFill_H              (iFill_H),
    .iFill_Colour         (iFill_Colour),
    .oBusy                (oBusy),
    .oDone                (oDone),
    .oDTL_CommandValid    (oDTL_CommandValid),
    .iDTL_CommandAccept   (iDTL_CommandAccept),
    .oDTL_Address         (oDTL_Address),
    .oDTL_CommandReadWrite(oDTL_CommandReadWrite),
    .oDTL_BlockSize       (oDTL_BlockSize),
    .oDTL_WriteValid      (oDTL_WriteValid),
    .oDTL_WriteLast       (oDTL_WriteLast),
    .iDTL_WriteAccept     (iDTL_WriteAccept),
    .oDTL_WriteEnable     (oDTL_WriteEnable),
    .oDTL_WriteData       (oDTL_WriteData),
    .oDebug_State         (oDebug_State)
  );

  // clock
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // count oDone pulses
  always @(negedge iClk) if (oDone === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int r, input int c);
    return 32'((r * 320 + c) * 4);
  endfunction

  // Wait for IDLE, present one fill command for one handshake, then scramble inputs.
  task automatic issue_cmd(input logic [8:0] x, input logic [7:0] y, input logic [9:0] w,
                           input logic [8:0] h, input logic [7:0] c);
    int n = 0;
    while (oFill_Accept !== 1'b1 && n < 50) begin
      @(negedge iClk);
      n++;
    end
    check("fill_accept_wait", 32'(oFill_Accept), 32'd1);
    iFill_X      = x;
    iFill_Y      = y;
    iFill_W      = w;
    iFill_H      = h;
    iFill_Colour = c;
    iFill_Valid  = 1'b1;
    @(negedge iClk);
    iFill_Valid  = 1'b0;
    iFill_X      = 9'($urandom_range(0, 511));
    iFill_Y      = 8'($urandom_range(0, 255));
    iFill_W      = 10'($urandom_range(0, 1023));
    iFill_H      = 9'($urandom_range(0, 511));
    iFill_Colour = 8'($urandom_range(0, 255));
  endtask

  // One burst: command phase with optional hold-off, then data beats.
  task automatic burst(input string tag, input logic [31:0] addr, input int len,
                       input logic [7:0] colour, input int cmd_wait, input bit toggle);
    int n = 0;
    int beats = 0;
    int guard = 0;
    bit acc;
    while (oDTL_CommandValid !== 1'b1 && n < 50) begin
      @(negedge iClk);
      n++;
    end
    check({tag, "_cmd_valid"}, 32'(oDTL_CommandValid), 32'd1);
    check({tag, "_addr"}, oDTL_Address, addr);
    check({tag, "_blocksize"}, 32'(oDTL_BlockSize), 32'(len - 1));
    check({tag, "_rw"}, 32'(oDTL_CommandReadWrite), 32'd1);
    check({tag, "_no_overlap"}, 32'(oDTL_WriteValid), 32'd0);
    for (int i = 0; i < cmd_wait; i++) begin
      iDTL_CommandAccept = 1'b0;
      @(negedge iClk);
      check({tag, "_hold_valid"}, 32'(oDTL_CommandValid), 32'd1);
      check({tag, "_hold_addr"}, oDTL_Address, addr);
      check({tag, "_hold_bs"}, 32'(oDTL_BlockSize), 32'(len - 1));
    end
    iDTL_CommandAccept = 1'b1;
    @(negedge iClk);
    iDTL_CommandAccept = 1'b0;
    check({tag, "_cmd_drop"}, 32'(oDTL_CommandValid), 32'd0);
    while (beats < len && guard < 200) begin
      acc = toggle ? guard[0] : 1'b1;
      check({tag, "_wvalid"}, 32'(oDTL_WriteValid), 32'd1);
      check({tag, "_wdata"}, oDTL_WriteData, {24'd0, colour});
      check({tag, "_wen"}, 32'(oDTL_WriteEnable), 32'hF);
      check({tag, "_wlast"}, 32'(oDTL_WriteLast), 32'(beats == len - 1));
      iDTL_WriteAccept = acc;
      @(negedge iClk);
      if (acc) beats++;
      guard++;
    end
    iDTL_WriteAccept = 1'b0;
    total_beats += beats;
    check({tag, "_beats"}, 32'(beats), 32'(len));
    check({tag, "_wvalid_end"}, 32'(oDTL_WriteValid), 32'd0);
  endtask

  // After the final burst: one NEXT cycle, one DONE cycle, then IDLE.
  task automatic finish_cmd(input string tag);
    @(negedge iClk);
    check({tag, "_done"}, 32'(oDone), 32'd1);
    check({tag, "_busy_done"}, 32'(oBusy), 32'd1);
    @(negedge iClk);
    check({tag, "_done_drop"}, 32'(oDone), 32'd0);
    check({tag, "_accept_back"}, 32'(oFill_Accept), 32'd1);
    check({tag, "_busy_drop"}, 32'(oBusy), 32'd0);
  endtask

  initial begin
    iReset             = 1'b1;
    iFill_Valid        = 1'b0;
    iFill_X            = '0;
    iFill_Y            = '0;
    iFill_W            = '0;
    iFill_H            = '0;
    iFill_Colour       = '0;
    iDTL_CommandAccept = 1'b0;
    iDTL_WriteAccept   = 1'b0;

    // reset state
    repeat (3) @(negedge iClk);
    check("rst_accept", 32'(oFill_Accept), 32'd0);
    check("rst_busy", 32'(oBusy), 32'd0);
    check("rst_done", 32'(oDone), 32'd0);
    check("rst_cmdvalid", 32'(oDTL_CommandValid), 32'd0);
    check("rst_addr", oDTL_Address, 32'd0);
    check("rst_rw", 32'(oDTL_CommandReadWrite), 32'd1);
    check("rst_wvalid", 32'(oDTL_WriteValid), 32'd0);
    check("rst_wen", 32'(oDTL_WriteEnable), 32'd0);
    check("rst_wdata", oDTL_WriteData, 32'd0);
    check("rst_state", 32'(oDebug_State), 32'd0);
    iReset = 1'b0;

    // single pixel at (5,2)
    issue_cmd(9'd5, 8'd2, 10'd1, 9'd1, 8'h3C);
    check("px_latency", 32'(oDTL_CommandValid), 32'd1);
    check("px_busy", 32'(oBusy), 32'd1);
    burst("px", 32'h0000_0A14, 1, 8'h3C, 0, 1'b0);
    finish_cmd("px");
    check("px_done_count", 32'(done_cnt), 32'd1);

    // row split: 20x2 at origin
    total_beats = 0;
    issue_cmd(9'd0, 8'd0, 10'd20, 9'd2, 8'hA5);
    burst("split0", 32'h000, 16, 8'hA5, 0, 1'b0);
    burst("split1", 32'h040, 4, 8'hA5, 0, 1'b0);
    burst("split2", 32'h500, 16, 8'hA5, 0, 1'b0);
    burst("split3", 32'h540, 4, 8'hA5, 0, 1'b0);
    finish_cmd("split");
    check("split_total_beats", 32'(total_beats), 32'd40);

    // backpressure: command held off 3 cycles, write accept toggling
    issue_cmd(9'd3, 8'd1, 10'd5, 9'd1, 8'h7E);
    burst("bp", 32'h50C, 5, 8'h7E, 3, 1'b1);
    finish_cmd("bp");

    // zero size: straight to DONE, no DTL traffic
    issue_cmd(9'd10, 8'd10, 10'd0, 9'd7, 8'h01);
    check("zero_done", 32'(oDone), 32'd1);
    check("zero_no_cmd", 32'(oDTL_CommandValid), 32'd0);
    @(negedge iClk);
    check("zero_done_drop", 32'(oDone), 32'd0);
    check("zero_no_cmd2", 32'(oDTL_CommandValid), 32'd0);
    check("zero_accept_back", 32'(oFill_Accept), 32'd1);

    // clip corner case
    issue_cmd(9'd310, 8'd238, 10'd20, 9'd5, 8'h5A);
`ifdef DTL_RECT_FILL_CLIP_EN
    for (int r = 0; r < 2; r++)
      burst("clip", exp_addr(238 + r, 310), 10, 8'h5A, 0, 1'b0);
`else
    for (int r = 0; r < 5; r++) begin
      burst("noclip_a", exp_addr(238 + r, 310), 16, 8'h5A, 0, 1'b0);
      burst("noclip_b", exp_addr(238 + r, 326), 4, 8'h5A, 0, 1'b0);
    end
`endif
    finish_cmd("clip");

    // reset during beat 3 of an 8-word burst
    issue_cmd(9'd0, 8'd0, 10'd8, 9'd1, 8'h11);
    check("rst_mid_cmd", 32'(oDTL_CommandValid), 32'd1);
    iDTL_CommandAccept = 1'b1;
    @(negedge iClk);
    iDTL_CommandAccept = 1'b0;
    iDTL_WriteAccept = 1'b1;
    repeat (3) @(negedge iClk);
    iDTL_WriteAccept = 1'b0;
    check("rst_mid_beat3_valid", 32'(oDTL_WriteValid), 32'd1);
    check("rst_mid_beat3_last", 32'(oDTL_WriteLast), 32'd0);
    iReset = 1'b1;
    @(negedge iClk);
    iReset = 1'b0;
    check("rst_mid_wvalid", 32'(oDTL_WriteValid), 32'd0);
    check("rst_mid_cvalid", 32'(oDTL_CommandValid), 32'd0);
    check("rst_mid_done", 32'(oDone), 32'd0);
    check("rst_mid_busy", 32'(oBusy), 32'd0);
    check("rst_mid_state", 32'(oDebug_State), 32'd0);
    @(negedge iClk);
    check("rst_mid_done2", 32'(oDone), 32'd0);
    check("rst_mid_accept", 32'(oFill_Accept), 32'd1);

    // fresh command after the abandoned one: bottom-right pixel
    issue_cmd(9'd319, 8'd239, 10'd1, 9'd1, 8'hFF);
    burst("post", 32'h0004_AFFC, 1, 8'hFF, 1, 1'b0);
    finish_cmd("post");
`ifdef DTL_RECT_FILL_CLIP_EN
    check("final_done_count", 32'(done_cnt), 32'd6);
`else
    check("final_done_count", 32'(done_cnt), 32'd6);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
